// File: rtl/spi_pkg.sv
// Shared constants for the SPI master timing path: FSM encoding, default
// geometry and the SPI mode to {CPOL,CPHA} mapping.
package spi_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_FRAME_BITS = 8;

    // Mode m occupies bits [2m+1:2m] as {CPOL,CPHA}.
    localparam logic [7:0] SPI_MODE_MAP = {2'b11, 2'b10, 2'b01, 2'b00};

    function automatic logic [1:0] spi_mode(input logic [1:0] mode);
        return SPI_MODE_MAP[{mode, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/spi_clk_divider.sv
// Free-running clk divider; tick marks the last cycle of each CLK_DIV-cycle
// period, and clear restarts the period from zero.
module spi_clk_divider
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;

    assign tick = (div_cnt_q == CNT_LAST);

    always_comb begin
        if (clear || tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_clkgen.sv
// SPI master timing engine: frames a transfer with chip-select, generates SCLK
// from the system clock and issues single-cycle sample/shift strobes.
module spi_master_clkgen
    import spi_pkg::*;
#(
    parameter int   CLK_DIV    = DEF_CLK_DIV,
    parameter int   FRAME_BITS = DEF_FRAME_BITS,
    parameter logic CPOL       = 1'b0,
    parameter logic CPHA       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic frame_done,
    output logic spi_clk,
    output logic spi_cs_n,
    output logic spi_clk_en,
    output logic spi_clk_recv_int,
    output logic spi_clk_send_int
);

    localparam int            EW        = $clog2(2 * FRAME_BITS);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * FRAME_BITS - 1);

    logic [1:0]    state_q,      state_d;
    logic [EW-1:0] edge_cnt_q,   edge_cnt_d;
    logic          busy_q,       busy_d;
    logic          frame_done_q, frame_done_d;
    logic          spi_clk_q,    spi_clk_d;
    logic          spi_cs_n_q,   spi_cs_n_d;
    logic          spi_clk_en_q, spi_clk_en_d;
    logic          recv_q,       recv_d;
    logic          send_q,       send_d;

    logic          tick;
    logic          div_clear;
    logic [EW-1:0] edge_inc;

    // Restart the divider whenever the state changes so every state starts at div_cnt 0.
    assign div_clear = (state_d != state_q);
    assign edge_inc  = edge_cnt_q + EW'(1);

    spi_clk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .clear (div_clear),
        .tick  (tick)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        spi_clk_d    = spi_clk_q;
        spi_cs_n_d   = spi_cs_n_q;
        spi_clk_en_d = spi_clk_en_q;
        recv_d       = 1'b0;
        send_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_SETUP;
                    busy_d       = 1'b1;
                    spi_cs_n_d   = 1'b0;
                    spi_clk_en_d = 1'b1;
                    send_d       = ~CPHA;
                end
            end
            ST_SETUP: begin
                // The SETUP tick launches edge 0 so RUN starts with SCLK already at its leading level.
                if (tick) begin
                    state_d    = ST_RUN;
                    edge_cnt_d = '0;
                    spi_clk_d  = ~CPOL;
                    recv_d     = ~CPHA;
                    send_d     = CPHA;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    if (edge_cnt_q == LAST_EDGE) begin
                        state_d = ST_HOLD;
                    end else begin
                        edge_cnt_d = edge_inc;
                        spi_clk_d  = ~spi_clk_q;
                        if (!edge_inc[0]) begin
                            recv_d = ~CPHA;
                            send_d = CPHA;
                        end else begin
                            recv_d = CPHA;
                            send_d = ~CPHA && (edge_inc != LAST_EDGE);
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d      = ST_IDLE;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                    spi_cs_n_d   = 1'b1;
                    spi_clk_en_d = 1'b0;
                    spi_clk_d    = CPOL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            edge_cnt_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            spi_clk_q    <= CPOL;
            spi_cs_n_q   <= 1'b1;
            spi_clk_en_q <= 1'b0;
            recv_q       <= 1'b0;
            send_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            spi_clk_q    <= spi_clk_d;
            spi_cs_n_q   <= spi_cs_n_d;
            spi_clk_en_q <= spi_clk_en_d;
            recv_q       <= recv_d;
            send_q       <= send_d;
        end
    end

    assign busy             = busy_q;
    assign frame_done       = frame_done_q;
    assign spi_clk          = spi_clk_q;
    assign spi_cs_n         = spi_cs_n_q;
    assign spi_clk_en       = spi_clk_en_q;
    assign spi_clk_recv_int = recv_q;
    assign spi_clk_send_int = send_q;

endmodule

// File: tb/tb_spi_master_clkgen.sv
// Bench for spi_master_clkgen: three configurations checked every cycle against
// a frame-position model, plus directed frames pinned to hand-computed numbers.
module tb_spi_master_clkgen;

    localparam int NI = 3;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [NI-1:0] start = '0;
    logic [NI-1:0] busy, frame_done, spi_clk, spi_cs_n, spi_clk_en, recv, send;

    int n_cmp = 0;
    int n_bad = 0;
    int k_m [NI];

    always #5 clk = ~clk;

    // u0: mode 0, defaults; u1: mode 3, CLK_DIV=1; u2: mode 2, CLK_DIV=3, one-bit frames.
    spi_master_clkgen #(.CLK_DIV(4), .FRAME_BITS(8), .CPOL(1'b0), .CPHA(1'b0)) u0 (
        .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]),
        .frame_done(frame_done[0]), .spi_clk(spi_clk[0]), .spi_cs_n(spi_cs_n[0]),
        .spi_clk_en(spi_clk_en[0]), .spi_clk_recv_int(recv[0]), .spi_clk_send_int(send[0]));

    spi_master_clkgen #(.CLK_DIV(1), .FRAME_BITS(8), .CPOL(1'b1), .CPHA(1'b1)) u1 (
        .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]),
        .frame_done(frame_done[1]), .spi_clk(spi_clk[1]), .spi_cs_n(spi_cs_n[1]),
        .spi_clk_en(spi_clk_en[1]), .spi_clk_recv_int(recv[1]), .spi_clk_send_int(send[1]));

    spi_master_clkgen #(.CLK_DIV(3), .FRAME_BITS(1), .CPOL(1'b1), .CPHA(1'b0)) u2 (
        .clk(clk), .reset(reset), .start(start[2]), .busy(busy[2]),
        .frame_done(frame_done[2]), .spi_clk(spi_clk[2]), .spi_cs_n(spi_cs_n[2]),
        .spi_clk_en(spi_clk_en[2]), .spi_clk_recv_int(recv[2]), .spi_clk_send_int(send[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void cfg(input int i, output int d, output int fb,
                                output logic cpol, output logic cpha);
        case (i)
            0:       begin d = 4; fb = 8; cpol = 1'b0; cpha = 1'b0; end
            1:       begin d = 1; fb = 8; cpol = 1'b1; cpha = 1'b1; end
            default: begin d = 3; fb = 1; cpol = 1'b1; cpha = 1'b0; end
        endcase
    endfunction

    function automatic int frame_len(input int i);
        int d, fb;
        logic cpol, cpha;
        cfg(i, d, fb, cpol, cpha);
        return d * (2 * fb + 2);
    endfunction

    // Expected {busy, frame_done, spi_clk, spi_cs_n, spi_clk_en, recv, send}
    // for cycle k after start was accepted (k = 0: idle).
    function automatic logic [6:0] expect_out(input int i, input int k);
        int d, fb, len, n, j;
        logic cpol, cpha, rv, sd, lead;
        cfg(i, d, fb, cpol, cpha);
        len = d * (2 * fb + 2);
        if (k == 0)       return {1'b0, 1'b0, cpol, 1'b1, 1'b0, 1'b0, 1'b0};
        if (k == len + 1) return {1'b0, 1'b1, cpol, 1'b1, 1'b0, 1'b0, 1'b0};
        // SCLK edge j lands on cycle d+1+j*d.
        n = (k <= d) ? 0 : ((k - d - 1) / d + 1);
        if (n > 2 * fb) n = 2 * fb;
        rv = 1'b0;
        sd = (k == 1) && !cpha;
        if (k > d && ((k - d - 1) % d) == 0 && ((k - d - 1) / d) < 2 * fb) begin
            j    = (k - d - 1) / d;
            lead = (j % 2) == 0;
            if (cpha) begin
                sd = lead;
                rv = !lead;
            end else begin
                rv = lead;
                sd = !lead && (j != 2 * fb - 1);
            end
        end
        return {1'b1, 1'b0, cpol ^ (n % 2 == 1), 1'b0, 1'b1, rv, sd};
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                k_m[i] <= 0;
            end else if (k_m[i] == 0 || k_m[i] == frame_len(i) + 1) begin
                k_m[i] <= start[i] ? 1 : 0;
            end else begin
                k_m[i] <= k_m[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            check($sformatf("model_u%0d_k%0d", i, k_m[i]),
                  {25'd0, busy[i], frame_done[i], spi_clk[i], spi_cs_n[i],
                   spi_clk_en[i], recv[i], send[i]},
                  {25'd0, expect_out(i, k_m[i])});
        end
    end

    task automatic wait_done(input int i, input int max_cyc, output int cyc);
        cyc = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (frame_done[i]) begin
                cyc = c;
                break;
            end
        end
    endtask

    // Mode 0 frame on u0, with a transmit/receive shift pair riding on the strobes.
    task automatic frame_mode0();
        int cs_low = 0, nrv = 0, nsd = 0, first_rv = -1, done_at = -1, bit_idx = 7;
        logic first_clk = 1'b0;
        logic mosi = 1'b0;
        logic [7:0]  tx = 8'hA5;
        logic [31:0] rx = '0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int c = 1; c <= 100 && done_at < 0; c++) begin
            if (!spi_cs_n[0]) cs_low++;
            if (send[0]) begin
                nsd++;
                if (bit_idx >= 0) mosi = tx[bit_idx];
                bit_idx--;
            end
            if (recv[0]) begin
                nrv++;
                rx = {rx[30:0], mosi};
                if (first_rv < 0) begin
                    first_rv  = c;
                    first_clk = spi_clk[0];
                end
            end
            if (frame_done[0]) done_at = c;
            if (done_at < 0) @(negedge clk);
        end
        check("m0_done_cycle", done_at, 73);
        check("m0_cs_low_cycles", cs_low, 72);
        check("m0_recv_count", nrv, 8);
        check("m0_send_count", nsd, 8);
        check("m0_first_recv_cycle", first_rv, 5);
        check("m0_first_recv_sclk_high", {31'd0, first_clk}, 1);
        check("m0_rdata", rx, 32'h0000_00A5);
    endtask

    task automatic frame_mode3();
        int nrv = 0, nsd = 0, bad = 0, done_at = -1;
        check("m3_sclk_idle_high", {31'd0, spi_clk[1]}, 1);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            if (recv[1]) begin
                nrv++;
                if (!spi_clk[1]) bad++;
            end
            if (send[1]) begin
                nsd++;
                if (spi_clk[1]) bad++;
            end
            if (recv[1] && send[1]) bad++;
            if (frame_done[1]) done_at = c;
            if (done_at < 0) @(negedge clk);
        end
        check("m3_done_cycle", done_at, 19);
        check("m3_recv_count", nrv, 8);
        check("m3_send_count", nsd, 8);
        check("m3_strobe_edge_errors", bad, 0);
    endtask

    initial begin
        int cyc, ndone;

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("reset_idle_u0", {25'd0, busy[0], frame_done[0], spi_clk[0], spi_cs_n[0],
                                spi_clk_en[0], recv[0], send[0]}, 32'b0001000);
        check("reset_idle_u1", {25'd0, busy[1], frame_done[1], spi_clk[1], spi_cs_n[1],
                                spi_clk_en[1], recv[1], send[1]}, 32'b0011000);

        frame_mode0();
        repeat (3) @(negedge clk);
        frame_mode3();
        repeat (3) @(negedge clk);

        // Back-to-back: start held high is taken again in the frame_done cycle.
        start[0] = 1'b1;
        wait_done(0, 200, cyc);
        check("b2b_first_done", cyc, 73);
        check("b2b_cs_high_in_done", {31'd0, spi_cs_n[0]}, 1);
        @(negedge clk);
        check("b2b_cs_low_next", {31'd0, spi_cs_n[0]}, 0);
        check("b2b_busy_next", {31'd0, busy[0]}, 1);
        start[0] = 1'b0;
        wait_done(0, 100, cyc);
        check("b2b_second_done", cyc, 72);

        // A start pulse in the middle of a frame must not queue a second frame.
        repeat (2) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (29) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        ndone = 0;
        repeat (100) begin
            @(negedge clk);
            if (frame_done[0]) ndone++;
        end
        check("midframe_start_done_count", ndone, 1);

        // Reset at cycle 30 of a frame.
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (29) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("reset_midframe_u0", {25'd0, busy[0], frame_done[0], spi_clk[0], spi_cs_n[0],
                                    spi_clk_en[0], recv[0], send[0]}, 32'b0001000);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (frame_done[0]) ndone++;
        end
        check("reset_midframe_no_done", ndone, 0);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, 100, cyc);
        check("after_reset_frame_done", cyc, 72);

        // Random starts on all instances, rare resets; the model checks every cycle.
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) start[i] = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 999) == 0) begin
                @(posedge clk);
                #1 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end
        start = '0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
